// File: rtl/mips_pipe_pkg.sv
// Shared types and encodings for the 5-stage MIPS pipeline registers.
package mips_pipe_pkg;

    localparam int ALU_OP_W = 2;

    localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose target is read by the instruction in ID.
module load_use_detect
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  hazard
);

    logic rt_nonzero;
    logic rs_match;
    logic rt_match;

    // $0 is hardwired, so a load targeting it never creates a dependency
    assign rt_nonzero = (ex_rt != REG_ADDR_W'(REG_ZERO));
    assign rs_match   = (ex_rt == id_rs);
    assign rt_match   = id_uses_rt & (ex_rt == id_rt);
    assign hazard     = id_valid & ex_valid & ex_mem_read & rt_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and PC / IF-ID write enables.
// Optional bubble counter (bubble_cnt, cnt_clr) is built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef ID_EX_PERF_CNT_EN
    input  logic                  cnt_clr,
    output logic [31:0]           bubble_cnt,
`endif
    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [ALUOP_W-1:0]    id_alu_op,
    input  logic                  id_uses_rt,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    input  logic                  stall_in,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  load_use_hazard
);

    ex_ctrl_t              id_ctrl;
    ex_ctrl_t              ctrl_q;
    logic                  valid_q;
    logic [DATA_W-1:0]     rd1_q, rd2_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic                  bubble;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
        .id_valid    (id_valid),
        .id_uses_rt  (id_uses_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .hazard      (load_use_hazard)
    );

    assign pc_write   = ~load_use_hazard & ~stall_in;
    assign ifid_write = ~load_use_hazard & ~stall_in;

    // An invalid ID slot enters EX as a bubble-equivalent: controls forced off
    always_comb begin
        id_ctrl = CTRL_BUBBLE;
        if (id_valid) begin
            id_ctrl.reg_write  = id_reg_write;
            id_ctrl.mem_read   = id_mem_read;
            id_ctrl.mem_write  = id_mem_write;
            id_ctrl.mem_to_reg = id_mem_to_reg;
            id_ctrl.alu_src    = id_alu_src;
            id_ctrl.reg_dst    = id_reg_dst;
            id_ctrl.alu_op     = id_alu_op;
        end
    end

    // Flush outranks stall; a hazard bubble only lands when the pipe is moving
    assign bubble = flush | (~stall_in & load_use_hazard);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else if (bubble) begin
            // Fields cleared too so a bubble looks like $0 to forwarding
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else if (!stall_in) begin
            valid_q <= id_valid;
            ctrl_q  <= id_ctrl;
            rd1_q   <= id_rd1;
            rd2_q   <= id_rd2;
            imm_q   <= id_imm;
            rs_q    <= id_rs;
            rt_q    <= id_rt;
            rd_q    <= id_rd;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_rd1        = rd1_q;
    assign ex_rd2        = rd2_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;

`ifdef ID_EX_PERF_CNT_EN
    logic hazard_bubble;
    assign hazard_bubble = load_use_hazard & ~stall_in & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (hazard_bubble && bubble_cnt != 32'hFFFF_FFFF) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic        uses_rt;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   flush = 1'b0;
    logic   stall_in = 1'b0;
    logic   cnt_clr = 1'b0;
    instr_t cur = '0;
    instr_t m = '0;
    longint m_cnt = 0;
    int     checks = 0;
    int     failures = 0;

    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        pc_write, ifid_write, load_use_hazard;
    logic [31:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .reset           (reset),
`ifdef ID_EX_PERF_CNT_EN
        .cnt_clr         (cnt_clr),
        .bubble_cnt      (bubble_cnt),
`endif
        .id_valid        (cur.valid),
        .id_reg_write    (cur.reg_write),
        .id_mem_read     (cur.mem_read),
        .id_mem_write    (cur.mem_write),
        .id_mem_to_reg   (cur.mem_to_reg),
        .id_alu_src      (cur.alu_src),
        .id_reg_dst      (cur.reg_dst),
        .id_alu_op       (cur.alu_op),
        .id_uses_rt      (cur.uses_rt),
        .id_rd1          (cur.rd1),
        .id_rd2          (cur.rd2),
        .id_imm          (cur.imm),
        .id_rs           (cur.rs),
        .id_rt           (cur.rt),
        .id_rd           (cur.rd),
        .flush           (flush),
        .stall_in        (stall_in),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_alu_src      (ex_alu_src),
        .ex_reg_dst      (ex_reg_dst),
        .ex_alu_op       (ex_alu_op),
        .ex_rd1          (ex_rd1),
        .ex_rd2          (ex_rd2),
        .ex_imm          (ex_imm),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .load_use_hazard (load_use_hazard)
    );

`ifndef ID_EX_PERF_CNT_EN
    assign bubble_cnt = '0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        return cur.valid && m.valid && m.mem_read && (m.rt != 5'd0) &&
               ((m.rt == cur.rs) || (cur.uses_rt && (m.rt == cur.rt)));
    endfunction

    task automatic check_ex();
        chk("ex_valid", ex_valid, m.valid);
        chk("ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op},
            {m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg, m.alu_src, m.reg_dst, m.alu_op});
        chk("ex_rd1", ex_rd1, m.rd1);
        chk("ex_rd2", ex_rd2, m.rd2);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_fields", {ex_rs, ex_rt, ex_rd}, {m.rs, m.rt, m.rd});
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", bubble_cnt, m_cnt[31:0]);
`endif
    endtask

    // One clock: check combinational outputs, advance the model across the edge, check registers
    task automatic cycle();
        logic hz;
        #1;
        hz = model_hazard();
        chk("load_use_hazard", load_use_hazard, hz);
        chk("pc_write", pc_write, !hz && !stall_in);
        chk("ifid_write", ifid_write, !hz && !stall_in);
        @(posedge clk);
        if (cnt_clr) m_cnt = 0;
        else if (hz && !stall_in && !flush && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (flush || (!stall_in && hz)) begin
            m = '0;
        end else if (!stall_in) begin
            m = cur;
            if (!cur.valid) begin
                m.reg_write = 0; m.mem_read = 0; m.mem_write = 0;
                m.mem_to_reg = 0; m.alu_src = 0; m.reg_dst = 0; m.alu_op = 2'b00;
            end
            m.uses_rt = 1'b0;
        end
        @(negedge clk);
        check_ex();
    endtask

    function automatic instr_t mk(input logic lw, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic uses_rt, input logic [31:0] rd1);
        instr_t i;
        i = '0;
        i.valid = 1'b1;
        i.reg_write = 1'b1;
        i.mem_read = lw;
        i.mem_to_reg = lw;
        i.alu_src = lw | ~uses_rt;
        i.reg_dst = ~lw & uses_rt;
        i.alu_op = (lw || !uses_rt) ? 2'b00 : 2'b10;
        i.uses_rt = uses_rt;
        i.rs = rs;
        i.rt = rt;
        i.rd = 5'd10;
        i.rd1 = rd1;
        i.rd2 = 32'hBEEF;
        i.imm = 32'h4;
        return i;
    endfunction

    initial begin
        // Reset phase
        @(negedge clk);
        @(negedge clk);
        check_ex();
        reset = 1'b0;
        chk("pc_write_after_reset", pc_write, 1'b1);

        // lw $8 then dependent add on rs
        cur = mk(1, 5'd1, 5'd8, 0, 32'h100);
        cycle();
        chk("lw_in_ex_rt", ex_rt, 5'd8);
        cur = mk(0, 5'd8, 5'd9, 1, 32'h200);
        #1;
        chk("lu_hazard_lit", load_use_hazard, 1'b1);
        chk("lu_pc_write_lit", pc_write, 1'b0);
        cycle();
        chk("lu_bubble_valid_lit", ex_valid, 1'b0);
        chk("lu_bubble_mr_lit", ex_mem_read, 1'b0);
        cycle();
        chk("lu_add_loaded_rs_lit", ex_rs, 5'd8);
        chk("lu_add_loaded_valid_lit", ex_valid, 1'b1);

        // lw $8 then addi writing rt=8 (rt not a source)
        cur = mk(1, 5'd1, 5'd8, 0, 32'h300);
        cycle();
        cur = mk(0, 5'd2, 5'd8, 0, 32'h400);
        #1;
        chk("addi_no_hazard_lit", load_use_hazard, 1'b0);
        cycle();
        chk("addi_loaded_lit", ex_rd1, 32'h400);

        // lw $0 never hazards
        cur = mk(1, 5'd1, 5'd0, 0, 32'h0);
        cycle();
        cur = mk(0, 5'd0, 5'd0, 1, 32'h1);
        #1;
        chk("lw_zero_no_hazard_lit", load_use_hazard, 1'b0);
        cycle();

        // flush together with a hazard
        cur = mk(1, 5'd1, 5'd8, 0, 32'h5);
        cycle();
        cur = mk(0, 5'd8, 5'd3, 1, 32'h6);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid_lit", ex_valid, 1'b0);
        chk("flush_fields_lit", {ex_rs, ex_rt}, 10'd0);

        // stall for 3 cycles holds an add
        cur = mk(0, 5'd4, 5'd5, 1, 32'h1234);
        cycle();
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur = mk(0, 5'd6, 5'd7, 1, 32'h9999 + k);
            #1;
            chk("stall_pc_write_lit", pc_write, 1'b0);
            cycle();
            chk("stall_hold_rd1_lit", ex_rd1, 32'h1234);
        end
        stall_in = 1'b0;

        // Reset asserted mid-cycle during a stalled hazard
        cur = mk(1, 5'd1, 5'd8, 0, 32'h77);
        cycle();
        cur = mk(0, 5'd8, 5'd8, 1, 32'h88);
        stall_in = 1'b1;
        #2;
        chk("pre_reset_hazard_lit", load_use_hazard, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_reset_valid_lit", ex_valid, 1'b0);
        chk("async_reset_rd1_lit", ex_rd1, 32'h0);
        chk("async_reset_hazard_lit", load_use_hazard, 1'b0);
        m = '0;
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        stall_in = 1'b0;
        cur = '0;
        #1;
        chk("post_reset_pc_write_lit", pc_write, 1'b1);
        cycle();

`ifdef ID_EX_PERF_CNT_EN
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cur = mk(1, 5'd1, 5'd8, 0, 32'h1);
            cycle();
            cur = mk(0, 5'd8, 5'd2, 1, 32'h2);
            cycle();
            cycle();
            cur = mk(0, 5'd3, 5'd4, 1, 32'h3);
            cycle();
        end
        chk("bubble_cnt_three_lit", bubble_cnt, 32'd3);
        cur = mk(1, 5'd1, 5'd8, 0, 32'h1);
        cycle();
        cur = mk(0, 5'd8, 5'd2, 1, 32'h2);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("bubble_cnt_clr_lit", bubble_cnt, 32'd0);
`endif

        // Randomized traffic with small register ranges to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            cur.valid      = ($urandom_range(0, 9) < 8);
            cur.reg_write  = 1'($urandom);
            cur.mem_read   = ($urandom_range(0, 2) == 0);
            cur.mem_write  = 1'($urandom);
            cur.mem_to_reg = 1'($urandom);
            cur.alu_src    = 1'($urandom);
            cur.reg_dst    = 1'($urandom);
            cur.alu_op     = 2'($urandom_range(0, 2));
            cur.uses_rt    = 1'($urandom);
            cur.rd1        = $urandom;
            cur.rd2        = $urandom;
            cur.imm        = $urandom;
            cur.rs         = 5'($urandom_range(0, 3));
            cur.rt         = 5'($urandom_range(0, 3));
            cur.rd         = 5'($urandom_range(0, 31));
            flush          = ($urandom_range(0, 9) == 0);
            stall_in       = ($urandom_range(0, 4) == 0);
            cnt_clr        = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
